// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg: shared widths, PC step and fetch FSM states
package pc_fetch_ctrl_pkg;
   localparam int PC_WIDTH = 16;
   localparam logic [PC_WIDTH-1:0] INSTR_STEP = 16'd2;
   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2, HALTED = 2'd3} state_e;
endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: sequential, branch and jump targets with jump > branch > sequential priority
module pc_next_calc
   import pc_fetch_ctrl_pkg::*;
(
   input  logic [PC_WIDTH-1:0] pc_i,
   input  logic [PC_WIDTH-1:0] instr_pc_i,
   input  logic                branch_taken_i,
   input  logic [7:0]          branch_offset_i,
   input  logic                jump_en_i,
   input  logic [PC_WIDTH-1:0] jump_addr_i,
   output logic [PC_WIDTH-1:0] seq_pc_o,
   output logic [PC_WIDTH-1:0] next_pc_o
);
   logic [PC_WIDTH-1:0] br_off, br_pc, jmp_pc;
   // offset counts instruction words, so scale by two after sign extension
   assign br_off    = {{(PC_WIDTH-9){branch_offset_i[7]}}, branch_offset_i, 1'b0};
   assign seq_pc_o  = pc_i + INSTR_STEP;
   assign br_pc     = instr_pc_i + INSTR_STEP + br_off;
   assign jmp_pc    = {jump_addr_i[PC_WIDTH-1:1], 1'b0};
   assign next_pc_o = jump_en_i ? jmp_pc : branch_taken_i ? br_pc : seq_pc_o;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetches one instruction at a time, holds it for decode,
// applies branch/jump redirects and supports halt/resume
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter logic [PC_WIDTH-1:0] RESET_PC = 16'h0000
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic [PC_WIDTH-1:0] pcOut,
   output logic                imemReq,
   input  logic                imemAck,
   input  logic [15:0]         instrIn,
   output logic [15:0]         instrOut,
   output logic [PC_WIDTH-1:0] instrPc,
   output logic                instrValid,
   input  logic                decodeReady,
   input  logic                branchTaken,
   input  logic [7:0]          branchOffset,
   input  logic                jumpEn,
   input  logic [PC_WIDTH-1:0] jumpAddr,
   input  logic                haltReq,
   input  logic                resume,
   output logic                halted
);
   state_e              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d, ipc_q, ipc_d, next_pc, seq_pc;
   logic [15:0]         instr_q, instr_d;
   logic                halt_pend_q, halt_pend_d, in_hold, redirect, halt_now;

   assign in_hold  = state_q == HOLD;
   assign redirect = in_hold & (jumpEn | branchTaken);
   assign halt_now = halt_pend_q | haltReq;

   // redirect inputs only count while an instruction is presented to decode
   pc_next_calc u_calc (
      .pc_i           (pc_q),
      .instr_pc_i     (ipc_q),
      .branch_taken_i (branchTaken & in_hold),
      .branch_offset_i(branchOffset),
      .jump_en_i      (jumpEn & in_hold),
      .jump_addr_i    (jumpAddr),
      .seq_pc_o       (seq_pc),
      .next_pc_o      (next_pc)
   );

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ipc_d       = ipc_q;
      instr_d     = instr_q;
      halt_pend_d = halt_pend_q;
      case (state_q)
         IDLE:    state_d = FETCH;
         FETCH: begin
            halt_pend_d = imemAck ? 1'b0 : halt_now;
            if (imemAck) begin
               state_d = halt_now ? HALTED : HOLD;
               instr_d = halt_now ? instr_q : instrIn;
               ipc_d   = halt_now ? ipc_q : pc_q;
               pc_d    = halt_now ? pc_q : seq_pc;
            end
         end
         HOLD: begin
            if (redirect | decodeReady) state_d = haltReq ? HALTED : FETCH;
            if (redirect) pc_d = next_pc;
         end
         HALTED:  state_d = resume ? FETCH : HALTED;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         ipc_q       <= '0;
         instr_q     <= '0;
         halt_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ipc_q       <= ipc_d;
         instr_q     <= instr_d;
         halt_pend_q <= halt_pend_d;
      end
   end

   assign pcOut      = pc_q;
   assign instrPc    = ipc_q;
   assign instrOut   = instr_q;
   assign imemReq    = state_q == FETCH;
   assign instrValid = in_hold;
   assign halted     = state_q == HALTED;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: table-driven cycle vectors plus hand-written reset sequences
module tb_pc_fetch_ctrl;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [15:0] pcOut, instrIn, instrOut, instrPc, jumpAddr;
   logic        imemReq, imemAck, instrValid, decodeReady, branchTaken, jumpEn, haltReq, resume, halted;
   logic [7:0]  branchOffset;
   int          n_cmp = 0, n_err = 0;

   typedef struct {
      logic ack, dr, br; logic [7:0] off; logic jmp; logic [15:0] ja; logic halt, res;
      logic [15:0] epc; logic ereq, eval, ehalt; logic [15:0] eipc;
   } vec_t;
   vec_t vecs[$];

   always #5 clk = ~clk;
   // memory returns a word derived from the requested address
   assign instrIn = pcOut ^ 16'hA5A5;

   pc_fetch_ctrl #(.RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n), .pcOut(pcOut), .imemReq(imemReq), .imemAck(imemAck),
      .instrIn(instrIn), .instrOut(instrOut), .instrPc(instrPc), .instrValid(instrValid),
      .decodeReady(decodeReady), .branchTaken(branchTaken), .branchOffset(branchOffset),
      .jumpEn(jumpEn), .jumpAddr(jumpAddr), .haltReq(haltReq), .resume(resume), .halted(halted)
   );

   function automatic vec_t mk(logic ack, logic dr, logic br, logic [7:0] off, logic jmp,
                               logic [15:0] ja, logic halt, logic res, logic [15:0] epc,
                               logic ereq, logic eval, logic ehalt, logic [15:0] eipc);
      vec_t v;
      v.ack = ack; v.dr = dr; v.br = br; v.off = off; v.jmp = jmp; v.ja = ja; v.halt = halt;
      v.res = res; v.epc = epc; v.ereq = ereq; v.eval = eval; v.ehalt = ehalt; v.eipc = eipc;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [15:0] epc, input logic ereq,
                            input logic eval, input logic ehalt, input logic [15:0] eipc);
      check({tag, " pcOut"}, pcOut, epc);
      check({tag, " imemReq"}, {15'd0, imemReq}, {15'd0, ereq});
      check({tag, " instrValid"}, {15'd0, instrValid}, {15'd0, eval});
      check({tag, " halted"}, {15'd0, halted}, {15'd0, ehalt});
      if (eval) begin
         check({tag, " instrPc"}, instrPc, eipc);
         check({tag, " instrOut"}, instrOut, eipc ^ 16'hA5A5);
      end
   endtask

   initial begin
      //               ack dr br off    jmp ja        hlt res  pc       req val hlt ipc
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 16'h0000));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 16'h0000));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0002, 0, 1, 0, 16'h0000));
      vecs.push_back(mk(0, 1, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0002, 1, 0, 0, 16'h0000));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0004, 0, 1, 0, 16'h0002));
      vecs.push_back(mk(0, 1, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0004, 1, 0, 0, 16'h0000));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0006, 0, 1, 0, 16'h0004));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0006, 0, 1, 0, 16'h0004));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0006, 0, 1, 0, 16'h0004));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0006, 0, 1, 0, 16'h0004));
      vecs.push_back(mk(0, 1, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0006, 1, 0, 0, 16'h0000));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0008, 0, 1, 0, 16'h0006));
      vecs.push_back(mk(0, 0, 0, 8'h00, 1, 16'h0011, 0, 0, 16'h0010, 1, 0, 0, 16'h0000));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0012, 0, 1, 0, 16'h0010));
      vecs.push_back(mk(0, 0, 1, 8'hFD, 0, 16'h0000, 0, 0, 16'h000C, 1, 0, 0, 16'h0000));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h000E, 0, 1, 0, 16'h000C));
      vecs.push_back(mk(0, 0, 0, 8'h00, 1, 16'h0011, 0, 0, 16'h0010, 1, 0, 0, 16'h0000));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0012, 0, 1, 0, 16'h0010));
      vecs.push_back(mk(0, 0, 1, 8'hFD, 1, 16'h1235, 0, 0, 16'h1234, 1, 0, 0, 16'h0000));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h1236, 0, 1, 0, 16'h1234));
      vecs.push_back(mk(0, 0, 0, 8'h00, 1, 16'hFFFF, 0, 0, 16'hFFFE, 1, 0, 0, 16'h0000));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 16'hFFFE));
      vecs.push_back(mk(0, 1, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 16'h0000));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0002, 0, 1, 0, 16'h0000));
      vecs.push_back(mk(0, 0, 0, 8'h00, 1, 16'hFFFE, 0, 0, 16'hFFFE, 1, 0, 0, 16'h0000));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 16'hFFFE));
      vecs.push_back(mk(0, 0, 1, 8'h01, 0, 16'h0000, 0, 0, 16'h0002, 1, 0, 0, 16'h0000));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0004, 0, 1, 0, 16'h0002));
      vecs.push_back(mk(0, 0, 0, 8'h00, 1, 16'h0020, 0, 0, 16'h0020, 1, 0, 0, 16'h0000));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 16'h0020, 1, 0, 0, 16'h0000));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0020, 1, 0, 0, 16'h0000));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0020, 0, 0, 1, 16'h0000));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0020, 0, 0, 1, 16'h0000));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 16'h0020, 0, 0, 1, 16'h0000));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 16'h0000, 0, 1, 16'h0020, 1, 0, 0, 16'h0000));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0022, 0, 1, 0, 16'h0020));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 16'h0022, 0, 1, 0, 16'h0020));
      vecs.push_back(mk(0, 1, 0, 8'h00, 0, 16'h0000, 1, 0, 16'h0022, 0, 0, 1, 16'h0000));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 16'h0000, 0, 1, 16'h0022, 1, 0, 0, 16'h0000));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0024, 0, 1, 0, 16'h0022));
      vecs.push_back(mk(0, 0, 0, 8'h00, 1, 16'h0040, 1, 0, 16'h0040, 0, 0, 1, 16'h0000));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 16'h0000, 0, 1, 16'h0040, 1, 0, 0, 16'h0000));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 16'h0000, 0, 1, 16'h0040, 1, 0, 0, 16'h0000));

      {imemAck, decodeReady, branchTaken, jumpEn, haltReq, resume} = '0;
      branchOffset = '0;
      jumpAddr     = '0;
      repeat (2) @(posedge clk);
      #1 check_all("reset", 16'h0000, 0, 0, 0, 16'h0000);
      check("reset instrPc", instrPc, 16'h0000);
      check("reset instrOut", instrOut, 16'h0000);
      @(negedge clk) rst_n = 1'b1;

      foreach (vecs[i]) begin
         imemAck = vecs[i].ack; decodeReady = vecs[i].dr; branchTaken = vecs[i].br;
         branchOffset = vecs[i].off; jumpEn = vecs[i].jmp; jumpAddr = vecs[i].ja;
         haltReq = vecs[i].halt; resume = vecs[i].res;
         @(posedge clk);
         #1 check_all($sformatf("v%0d", i), vecs[i].epc, vecs[i].ereq, vecs[i].eval,
                      vecs[i].ehalt, vecs[i].eipc);
      end

      // asynchronous reset mid-fetch at 0040, with a late ack held across release
      {decodeReady, branchTaken, jumpEn, haltReq, resume} = '0;
      #1 rst_n = 1'b0; imemAck = 1'b1;
      #1 check_all("async_rst", 16'h0000, 0, 0, 0, 16'h0000);
      check("async_rst instrPc", instrPc, 16'h0000);
      check("async_rst instrOut", instrOut, 16'h0000);
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1 check_all("late_ack", 16'h0000, 1, 0, 0, 16'h0000);
      @(posedge clk);
      #1 check_all("refetch", 16'h0002, 0, 1, 0, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, the PC loaded on reset.
REQ-002 The block SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port pcOut  out  16  address presented to instruction memory.
REQ-005 The block SHALL have port imemReq  out  1  fetch request to instruction memory.
REQ-006 The block SHALL have port imemAck  in  1  memory response; instrIn is valid in the same cycle.
REQ-007 The block SHALL have port instrIn  in  16  instruction word from memory.
REQ-008 The block SHALL have port instrOut/instrPc  out  16/16  held instruction and its address.
REQ-009 The block SHALL have port instrValid  out  1  instrOut/instrPc valid to decode.
REQ-010 The block SHALL have port decodeReady  in  1  decode accepts the instruction when instrValid && decodeReady.
REQ-011 The block SHALL have ports branchTaken  in  1  and branchOffset  in  8  (signed, in instruction words).
REQ-012 The block SHALL have ports jumpEn  in  1  and jumpAddr  in  16  (absolute target).
REQ-013 The block SHALL have ports haltReq  in  1,  resume  in  1,  and halted  out  1.

Function
REQ-014 The block SHALL implement FSM states IDLE, FETCH, HOLD, HALTED.
REQ-015 IDLE SHALL go to FETCH on the first clock after reset release.
REQ-016 In FETCH, imemReq SHALL be 1, pcOut SHALL be stable, and the block SHALL stay in FETCH until imemAck.
REQ-017 On imemAck with no pending redirect, the block SHALL capture instrIn/pcOut into instrOut/instrPc, set instrValid next cycle, go to HOLD, and load PC = pcOut + 2.
REQ-018 In HOLD, an accepted handshake with no redirect and no halt SHALL clear instrValid and go to FETCH.
REQ-019 A redirect SHALL be sampled only while instrValid=1.
REQ-020 Redirect priority SHALL be jumpEn, then branchTaken, then sequential.
REQ-021 The jump target SHALL be {jumpAddr[15:1],1'b0}.
REQ-022 The branch target SHALL be instrPc + 2 + (sign-extended branchOffset << 1), computed modulo 2^16.
REQ-023 On a redirect in HOLD, the block SHALL clear instrValid, load the target into PC, and go to FETCH without waiting for decodeReady.
REQ-024 PC+2 from 16'hFFFE SHALL wrap to 16'h0000, and target arithmetic SHALL wrap the same way, with no error flag.
REQ-025 When haltReq is high in HOLD on an accepted handshake, the block SHALL go to HALTED with instrValid=0, imemReq=0, halted=1, and PC frozen.
REQ-026 When haltReq arrives in FETCH, the block SHALL record it and, after imemAck, discard the fetched word and go to HALTED without advancing PC.
REQ-027 HALTED SHALL go to FETCH on resume=1; haltReq and resume SHALL be ignored in every other state.
REQ-028 Redirect and halt in the same cycle: the block SHALL load the redirect PC, then enter HALTED.
REQ-029 Outside FETCH, imemReq SHALL be 0; outside HOLD, instrValid SHALL be 0.

Reset
REQ-030 On rst_n=0 asynchronously: state=IDLE, PC=pcOut=RESET_PC, instrOut=instrPc=0, instrValid=imemReq=halted=0, and the pending-halt flag is cleared.
REQ-031 Reset asserted mid-fetch or mid-hold SHALL abandon the transaction, and any late imemAck after reset SHALL be ignored until FETCH is re-entered.

Structure
REQ-032 A shared package SHALL hold the state enum, PC_WIDTH=16, and INSTR_STEP=2.
REQ-033 A single sub-module pc_next_calc SHALL be combinational and compute the sequential, branch, and jump targets plus the priority mux.

Verification
REQ-034 Reset release, imemAck after 1 cycle, decodeReady=1 -> pcOut sequence 0000,0002,0004, each instruction presented with the correct instrPc.
REQ-035 decodeReady=0 for 3 cycles in HOLD -> instrOut/instrValid held stable and pcOut unchanged until acceptance.
REQ-036 instrPc=0010, branchTaken with offset=-3 (8'hFD) -> next pcOut=000C; with jumpEn=1 and jumpAddr=1235 in the same cycle -> pcOut=1234.
REQ-037 instrPc=FFFE, sequential -> next fetch at 0000; offset=+1 at FFFE -> 0002.
REQ-038 haltReq during FETCH at pcOut=0020 -> halted=1 after ack, instrValid never set; resume -> refetch at 0020.
REQ-039 rst_n low while imemReq=1 at pcOut=0040 -> all outputs immediately reset, and the next fetch is at RESET_PC.
